logic_gate_pipe: RTL

- Parametrised, pipelined successor to the single-bit inverter.
- Applies one of eight bitwise logic operations (NOT among them) to WIDTH-bit operands.
- Moves data through a STAGES-deep register pipeline with valid/ready flow control on both sides.
- Serves as the team's reusable registered logic-op element and as a flow-control exercise target for benches.

---
 rtl/logic_gate_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/logic_gate_pipe.sv
// Registered bitwise logic-op element: eight ops on WIDTH-bit operands through a
// STAGES-deep valid/ready pipeline with collapsing bubbles and a transfer counter.
module logic_gate_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [2:0]       out_op,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int unsigned LAST = STAGES - 1;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_BUF  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] res;
    } beat_t;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] adv;
    beat_t             stg_q [STAGES];
    beat_t             stg_d [STAGES];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [WIDTH-1:0]  res_c;
    logic              accept;

    // Operation applied to the incoming beat.
    always_comb begin
        res_c = '0;
        case (op_e'(op))
            OP_NOT:  res_c = ~a;
            OP_BUF:  res_c = a;
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_NAND: res_c = ~(a & b);
            OP_NOR:  res_c = ~(a | b);
            OP_XNOR: res_c = ~(a ^ b);
            default: res_c = '0;
        endcase
    end

    // A stage may advance unless it and every stage downstream of it are full while stalled.
    always_comb begin
        logic full_tail;
        adv       = '0;
        full_tail = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            full_tail = 1'b1;
            for (int unsigned j = k; j < STAGES; j++) begin
                full_tail = full_tail & vld_q[j];
            end
            adv[k] = out_ready | ~full_tail;
        end
    end

    assign in_ready = adv[0];
    assign accept   = in_valid & adv[0];

    // Data only moves with a valid beat, so an emptied stage keeps its last contents.
    always_comb begin
        vld_d = vld_q;
        stg_d = stg_q;
        cnt_d = cnt_q;
        if (adv[0]) begin
            vld_d[0] = accept;
            if (accept) begin
                stg_d[0].op  = op;
                stg_d[0].res = res_c;
            end
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    stg_d[k] = stg_q[k-1];
                end
            end
        end
        if (vld_q[LAST] & out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            stg_q <= stg_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign o         = stg_q[LAST].res;
    assign out_op    = stg_q[LAST].op;
    assign busy      = |vld_q;
    assign xfer_cnt  = cnt_q;

endmodule
